ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline. Sits between ID and MEM, and produces the bus that MEM consumes.
- Registers the ID→EX bus and performs ALU operations.
- Computes the load/store address, byte enables and store data, and drives the data SRAM request.
- Contains an iterative 32-cycle divider that writes the HI/LO registers. While a divide is in progress it raises a stall request.

---
 rtl/ex_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Registers the ID->EX bus and runs the ALU. Drives the data SRAM request and
// the forwarding outputs. Holds HI/LO and a 32-step restoring divider that
// requests a stall while it is busy.
// Optional feature: define EX_MUL_EN to add a single-cycle signed MULT (div_op=11).
module ex_stage #(
  parameter int unsigned ID_TO_EX_WD  = 149,
  parameter int unsigned EX_TO_MEM_WD = 107,
  parameter int unsigned DIV_CYCLES   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_we_o,
  output logic [4:0]              ex_waddr_o,
  output logic [31:0]             ex_wdata_o,
  output logic                    ex_is_load_o,
  output logic                    stallreq_ex,
  output logic [31:0]             ex_pc_o
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam int unsigned PAD_W = EX_TO_MEM_WD - 80;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  logic [ID_TO_EX_WD-1:0] id_ex_q, id_ex_d;

  logic [31:0] pc, src1, src2, rt_data;
  logic [3:0]  alu_op;
  logic [1:0]  mem_op, mem_size, div_op;
  logic        data_ram_en, sel_rf_res, rf_we;
  logic [4:0]  rf_waddr;
  logic [2:0]  hilo_op;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] ex_result;
  logic [3:0]  sram_wen;
  logic [31:0] sram_wdata;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             wrote_q, wrote_d;

  logic        div_start, div_signed;
  logic [31:0] abs1, abs2, quo_fix, rem_fix;
  logic [32:0] shifted;

  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  assign {pc, alu_op, src1, src2, rt_data, mem_op, mem_size, data_ram_en,
          sel_rf_res, rf_we, rf_waddr, div_op, hilo_op} = id_ex_q;

  // Pipeline register next value: bubble, load or hold.
  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[2] && !stall[3]) begin
      id_ex_d = '0;
    end else if (!stall[2]) begin
      id_ex_d = id_to_ex_bus;
    end
  end

  // ALU result, available in the same cycle the instruction sits in EX.
  always_comb begin
    ex_result = '0;
    case (alu_op)
      4'd0:    ex_result = src1 + src2;
      4'd1:    ex_result = src1 - src2;
      4'd2:    ex_result = {31'b0, $signed(src1) < $signed(src2)};
      4'd3:    ex_result = {31'b0, src1 < src2};
      4'd4:    ex_result = src1 & src2;
      4'd5:    ex_result = src1 | src2;
      4'd6:    ex_result = src1 ^ src2;
      4'd7:    ex_result = ~(src1 | src2);
      4'd8:    ex_result = src2 << src1[4:0];
      4'd9:    ex_result = src2 >> src1[4:0];
      4'd10:   ex_result = 32'($signed(src2) >>> src1[4:0]);
      4'd11:   ex_result = {src2[15:0], 16'b0};
      4'd12:   ex_result = hi_q;
      4'd13:   ex_result = lo_q;
      default: ex_result = '0;
    endcase
  end

  // Store byte enables and lane-replicated store data.
  always_comb begin
    sram_wen   = 4'b0000;
    sram_wdata = rt_data;
    case (mem_size)
      2'b00:   sram_wdata = {4{rt_data[7:0]}};
      2'b01:   sram_wdata = {2{rt_data[15:0]}};
      default: sram_wdata = rt_data;
    endcase
    if (mem_op == 2'b10) begin
      case (mem_size)
        2'b00:   sram_wen = 4'b0001 << ex_result[1:0];
        2'b01:   sram_wen = ex_result[1] ? 4'b1100 : 4'b0011;
        2'b10:   sram_wen = 4'b1111;
        default: sram_wen = 4'b0000;
      endcase
    end
  end

  // Divider operand preparation and result sign fixup.
  assign div_start  = (div_op == 2'b01) || (div_op == 2'b10);
  assign div_signed = (div_op == 2'b01);
  assign abs1       = (div_signed && src1[31]) ? (~src1 + 32'd1) : src1;
  assign abs2       = (div_signed && src2[31]) ? (~src2 + 32'd1) : src2;
  assign quo_fix    = q_neg_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix    = r_neg_q ? (~rem_q + 32'd1) : rem_q;
  assign shifted    = {rem_q, quo_q[31]};
  assign stallreq_ex = div_start && (state_q != S_DONE);

  // Divider next-state and datapath: one restoring step per BUSY cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    wrote_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_start) begin
          cnt_d   = '0;
          q_neg_d = div_signed && (src1[31] ^ src2[31]);
          r_neg_d = div_signed && src1[31];
          if (src2 == 32'd0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = src1;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end else begin
            state_d = S_BUSY;
            quo_d   = abs1;
            rem_d   = '0;
            dvs_d   = abs2;
          end
        end
      end
      S_BUSY: begin
        if (shifted >= {1'b0, dvs_q}) begin
          rem_d = 32'(shifted - {1'b0, dvs_q});
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wrote_d = 1'b1;
        if (!stall[2]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef EX_MUL_EN
  logic [63:0] mul_prod;
  assign mul_prod = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
`endif

  // HI/LO update: divider result once on entering DONE, else MTHI/MTLO/MULT on advance.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if ((state_q == S_DONE) && !wrote_q) begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end else if (!stall[2]) begin
      if (hilo_op == 3'b001) begin
        hi_d = src1;
      end else if (hilo_op == 3'b010) begin
        lo_d = src1;
      end
`ifdef EX_MUL_EN
      if (div_op == 2'b11) begin
        hi_d = mul_prod[63:32];
        lo_d = mul_prod[31:0];
      end
`else
      // div_op=11 leaves HI/LO untouched in this build.
`endif
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      wrote_q <= 1'b0;
    end else begin
      id_ex_q <= id_ex_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      wrote_q <= wrote_d;
    end
  end

  assign data_sram_en    = data_ram_en;
  assign data_sram_wen   = sram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = sram_wdata;
  assign ex_we_o         = rf_we;
  assign ex_waddr_o      = rf_waddr;
  assign ex_wdata_o      = ex_result;
  assign ex_is_load_o    = (mem_op == 2'b01);
  assign ex_pc_o         = pc;
  assign ex_to_mem_bus   = {pc, data_ram_en, sram_wen, mem_op, mem_size, sel_rf_res,
                            rf_we, rf_waddr, ex_result, {PAD_W{1'b0}}};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage (table vectors, directed
// divider/stall/reset sequences, and randomized stimulus against a reference model).
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [148:0] id_bus;
  logic [106:0] ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         ex_we_o;
  logic [4:0]   ex_waddr_o;
  logic [31:0]  ex_wdata_o;
  logic         ex_is_load_o, stallreq_ex;
  logic [31:0]  ex_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .ex_we_o(ex_we_o), .ex_waddr_o(ex_waddr_o),
    .ex_wdata_o(ex_wdata_o), .ex_is_load_o(ex_is_load_o), .stallreq_ex(stallreq_ex),
    .ex_pc_o(ex_pc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] s1, s2, rt;
    logic [1:0]  mop, msz;
    logic [31:0] res;
    logic [3:0]  wen;
    logic [31:0] wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [106:0] act, input logic [106:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [148:0] mk(input logic [31:0] pc, input logic [3:0] alu,
      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rt,
      input logic [1:0] mop, input logic [1:0] msz, input logic en, input logic sel,
      input logic we, input logic [4:0] waddr, input logic [1:0] dop, input logic [2:0] hop);
    return {pc, alu, s1, s2, rt, mop, msz, en, sel, we, waddr, dop, hop};
  endfunction

  function automatic logic [106:0] exp_bus(input logic [31:0] pc, input logic en,
      input logic [3:0] wen, input logic [1:0] mop, input logic [1:0] msz, input logic sel,
      input logic we, input logic [4:0] waddr, input logic [31:0] res);
    return {pc, en, wen, mop, msz, sel, we, waddr, res, 27'b0};
  endfunction

  function automatic logic [148:0] i_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return mk(32'h0000_0100, op, a, b, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd1, 2'b00, 3'b000);
  endfunction

  function automatic logic [148:0] i_div(input logic [1:0] dop, input logic [31:0] a, input logic [31:0] b);
    return mk(32'h0000_0200, 4'd0, a, b, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, dop, 3'b000);
  endfunction

  function automatic logic [148:0] i_mt(input logic [2:0] hop, input logic [31:0] v);
    return mk(32'h0000_0300, 4'd0, v, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, hop);
  endfunction

  // Reference ALU written with wide integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    longint sa, sb, p2;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p2 = longint'(64'd1 << a[4:0]);
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua - ub);
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~(a | b);
      4'd8:  return 32'(ub * 64'(p2));
      4'd9:  return 32'(ub / 64'(p2));
      4'd10: return 32'((sb - ((sb < 0) ? (p2 - 1) : 0)) / p2);
      4'd11: return 32'(ub * 64'd65536);
      4'd12: return hi;
      4'd13: return lo;
      default: return 32'h0;
    endcase
  endfunction

  // Reference store lanes: an access of nb bytes covers lanes aligned down to nb.
  function automatic void ref_store(input logic [1:0] mop, input logic [1:0] msz,
      input logic [31:0] addr, input logic [31:0] rt, output logic [3:0] wen, output logic [31:0] wd);
    int nb, base;
    nb   = (msz == 2'b00) ? 1 : (msz == 2'b01) ? 2 : 4;
    base = (int'(addr[1:0]) / nb) * nb;
    wen  = 4'b0000;
    wd   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (mop == 2'b10 && i >= base && i < base + nb) wen[i] = 1'b1;
      wd[8*i +: 8] = rt[8*(i % nb) +: 8];
    end
  endfunction

  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
      output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic issue(input logic [148:0] b);
    id_bus = b;
    stall  = 6'b000000;
    @(posedge clk);
    #1;
  endtask

  // Runs a divide like the stall controller would: hold IF..EX while stallreq_ex.
  task automatic run_div(input logic [148:0] b, output int cycles);
    issue(b);
    cycles = 0;
    while (stallreq_ex && cycles < 200) begin
      cycles++;
      stall  = 6'b001111;
      id_bus = '0;
      @(posedge clk);
      #1;
    end
    stall = 6'b000000;
  endtask

  vec_t vt[20];
  logic [31:0] m_hi, m_lo, q, r, a, b, rt, res;
  logic [3:0]  wen;
  logic [31:0] wd;
  int          cyc;

  initial begin
    vt[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h1,         32'h0, 2'b00, 2'b00, 32'h8000_0000, 4'b0000, 32'h0};
    vt[1]  = '{4'd1,  32'h5,         32'h7,         32'h0, 2'b00, 2'b00, 32'hFFFF_FFFE, 4'b0000, 32'h0};
    vt[2]  = '{4'd2,  32'hFFFF_FFFF, 32'h1,         32'h0, 2'b00, 2'b00, 32'h1,         4'b0000, 32'h0};
    vt[3]  = '{4'd3,  32'hFFFF_FFFF, 32'h1,         32'h0, 2'b00, 2'b00, 32'h0,         4'b0000, 32'h0};
    vt[4]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 2'b00, 2'b00, 32'hF000_F000, 4'b0000, 32'h0};
    vt[5]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 2'b00, 2'b00, 32'hFFF0_FFF0, 4'b0000, 32'h0};
    vt[6]  = '{4'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 2'b00, 2'b00, 32'h0FF0_0FF0, 4'b0000, 32'h0};
    vt[7]  = '{4'd7,  32'h0,         32'h0,         32'h0, 2'b00, 2'b00, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    vt[8]  = '{4'd8,  32'h4,         32'hF,         32'h0, 2'b00, 2'b00, 32'hF0,        4'b0000, 32'h0};
    vt[9]  = '{4'd9,  32'h4,         32'h8000_0000, 32'h0, 2'b00, 2'b00, 32'h0800_0000, 4'b0000, 32'h0};
    vt[10] = '{4'd10, 32'h4,         32'h8000_0000, 32'h0, 2'b00, 2'b00, 32'hF800_0000, 4'b0000, 32'h0};
    vt[11] = '{4'd8,  32'h24,        32'h1,         32'h0, 2'b00, 2'b00, 32'h10,        4'b0000, 32'h0};
    vt[12] = '{4'd11, 32'h0,         32'h1234_ABCD, 32'h0, 2'b00, 2'b00, 32'hABCD_0000, 4'b0000, 32'h0};
    vt[13] = '{4'd14, 32'h1,         32'h2,         32'h0, 2'b00, 2'b00, 32'h0,         4'b0000, 32'h0};
    vt[14] = '{4'd0,  32'h1000, 32'h3, 32'h0000_00AB, 2'b10, 2'b00, 32'h1003, 4'b1000, 32'hABAB_ABAB};
    vt[15] = '{4'd0,  32'h1000, 32'h2, 32'h0000_BEEF, 2'b10, 2'b01, 32'h1002, 4'b1100, 32'hBEEF_BEEF};
    vt[16] = '{4'd0,  32'h1000, 32'h0, 32'h1234_5678, 2'b10, 2'b10, 32'h1000, 4'b1111, 32'h1234_5678};
    vt[17] = '{4'd0,  32'h1000, 32'h4, 32'h1234_5678, 2'b01, 2'b10, 32'h1004, 4'b0000, 32'h0};
    vt[18] = '{4'd0,  32'h1000, 32'h0, 32'h0000_0055, 2'b10, 2'b00, 32'h1000, 4'b0001, 32'h5555_5555};
    vt[19] = '{4'd15, 32'h1,         32'h2,         32'h0, 2'b00, 2'b00, 32'h0,         4'b0000, 32'h0};

    // Reset state.
    rst = 1'b1;
    stall = 6'b000000;
    id_bus = mk(32'hDEAD_BEEF, 4'd5, 32'h1, 32'h2, 32'h3, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 5'd7, 2'b01, 3'b001);
    repeat (2) @(posedge clk);
    #1;
    chk_bus("reset_bus", ex_to_mem_bus, 107'h0);
    chk("reset_sram", {data_sram_en, data_sram_wen, data_sram_addr[26:0]}, 32'h0);
    chk("reset_addr", data_sram_addr, 32'h0);
    chk("reset_wdata", data_sram_wdata, 32'h0);
    chk("reset_fwd", {ex_we_o, ex_waddr_o, ex_is_load_o, stallreq_ex}, 32'h0);
    chk("reset_wdata_o", ex_wdata_o, 32'h0);
    chk("reset_pc", ex_pc_o, 32'h0);
    rst = 1'b0;
    issue(i_alu(4'd12, 32'h0, 32'h0));
    chk("reset_hi", ex_wdata_o, 32'h0);
    issue(i_alu(4'd13, 32'h0, 32'h0));
    chk("reset_lo", ex_wdata_o, 32'h0);

    // Table-driven ALU and load/store vectors.
    for (int i = 0; i < 20; i++) begin
      issue(mk(32'h4000 + 32'(4 * i), vt[i].alu, vt[i].s1, vt[i].s2, vt[i].rt, vt[i].mop, vt[i].msz,
               vt[i].mop != 2'b00, 1'b0, 1'b1, 5'(i), 2'b00, 3'b000));
      chk($sformatf("vec%0d_result", i), ex_wdata_o, vt[i].res);
      chk($sformatf("vec%0d_wen", i), 32'(data_sram_wen), 32'(vt[i].wen));
      chk($sformatf("vec%0d_addr", i), data_sram_addr, vt[i].res);
      if (vt[i].mop == 2'b10) chk($sformatf("vec%0d_wdata", i), data_sram_wdata, vt[i].wd);
      chk($sformatf("vec%0d_ctl", i), {28'h0, data_sram_en, ex_is_load_o, ex_we_o, stallreq_ex},
          {28'h0, vt[i].mop != 2'b00, vt[i].mop == 2'b01, 1'b1, 1'b0});
      chk_bus($sformatf("vec%0d_bus", i), ex_to_mem_bus,
              exp_bus(32'h4000 + 32'(4 * i), vt[i].mop != 2'b00, vt[i].wen, vt[i].mop, vt[i].msz,
                      1'b0, 1'b1, 5'(i), vt[i].res));
    end

    // Hold then bubble.
    issue(mk(32'h0000_0500, 4'd0, 32'h3, 32'h4, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 3'b000));
    id_bus = i_alu(4'd5, 32'hFF, 32'h0);
    stall = 6'b001100;
    @(posedge clk);
    #1;
    chk_bus("hold_bus", ex_to_mem_bus, exp_bus(32'h500, 1'b0, 4'b0, 2'b00, 2'b00, 1'b1, 1'b1, 5'd5, 32'h7));
    stall = 6'b000100;
    @(posedge clk);
    #1;
    chk_bus("bubble_bus", ex_to_mem_bus, 107'h0);
    chk("bubble_pc", ex_pc_o, 32'h0);

    // DIV -7/2, held in DONE by downstream for a few cycles, then MFLO/MFHI.
    run_div(i_div(2'b01, 32'hFFFF_FFF9, 32'h2), cyc);
    chk("div_stall_cycles", 32'(cyc), 32'd33);
    for (int k = 0; k < 3; k++) begin
      stall = 6'b001100;
      @(posedge clk);
      #1;
      chk("div_done_hold_nostall", 32'(stallreq_ex), 32'd0);
    end
    issue(i_alu(4'd13, 32'h0, 32'h0));
    chk("div_lo", ex_wdata_o, 32'hFFFF_FFFD);
    issue(i_alu(4'd12, 32'h0, 32'h0));
    chk("div_hi", ex_wdata_o, 32'hFFFF_FFFF);

    // DIVU 5/0.
    run_div(i_div(2'b10, 32'h5, 32'h0), cyc);
    chk("divu0_stall_cycles", 32'(cyc), 32'd1);
    issue(i_alu(4'd13, 32'h0, 32'h0));
    chk("divu0_lo", ex_wdata_o, 32'hFFFF_FFFF);
    issue(i_alu(4'd12, 32'h0, 32'h0));
    chk("divu0_hi", ex_wdata_o, 32'h5);

    // Reset in the middle of a divide.
    issue(i_div(2'b10, 32'd100, 32'd7));
    for (int k = 0; k < 10; k++) begin
      chk("middiv_stallreq", 32'(stallreq_ex), 32'd1);
      stall = 6'b001111;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    stall = 6'b000000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("middiv_rst_stallreq", 32'(stallreq_ex), 32'd0);
    issue(i_alu(4'd12, 32'h0, 32'h0));
    chk("middiv_rst_hi", ex_wdata_o, 32'h0);
    issue(i_alu(4'd13, 32'h0, 32'h0));
    chk("middiv_rst_lo", ex_wdata_o, 32'h0);
    run_div(i_div(2'b10, 32'd10, 32'd3), cyc);
    chk("postrst_div_cycles", 32'(cyc), 32'd33);
    issue(i_alu(4'd13, 32'h0, 32'h0));
    chk("postrst_div_lo", ex_wdata_o, 32'd3);
    issue(i_alu(4'd12, 32'h0, 32'h0));
    chk("postrst_div_hi", ex_wdata_o, 32'd1);

    // MULT 0xFFFFFFFF x 2 after known HI/LO.
    issue(i_mt(3'b001, 32'h1111_1111));
    issue(i_mt(3'b010, 32'h2222_2222));
    issue(i_div(2'b11, 32'hFFFF_FFFF, 32'h2));
    chk("mult_nostall", 32'(stallreq_ex), 32'd0);
    issue(i_alu(4'd12, 32'h0, 32'h0));
`ifdef EX_MUL_EN
    chk("mult_hi", ex_wdata_o, 32'hFFFF_FFFF);
`else
    chk("mult_hi", ex_wdata_o, 32'h1111_1111);
`endif
    issue(i_alu(4'd13, 32'h0, 32'h0));
`ifdef EX_MUL_EN
    chk("mult_lo", ex_wdata_o, 32'hFFFF_FFFE);
`else
    chk("mult_lo", ex_wdata_o, 32'h2222_2222);
`endif

    // Randomized stream against the reference model.
    m_hi = $urandom;
    m_lo = $urandom;
    issue(i_mt(3'b001, m_hi));
    issue(i_mt(3'b010, m_lo));
    for (int it = 0; it < 300; it++) begin
      int sel;
      logic [3:0] op;
      logic [1:0] mop, msz;
      sel = int'($urandom_range(0, 9));
      a   = $urandom;
      b   = $urandom;
      rt  = $urandom;
      if (sel <= 4) begin
        op = 4'($urandom_range(0, 15));
        issue(i_alu(op, a, b));
        chk($sformatf("rand_alu_op%0d", op), ex_wdata_o, ref_alu(op, a, b, m_hi, m_lo));
      end else if (sel == 5) begin
        mop = 2'($urandom_range(0, 2));
        msz = 2'($urandom_range(0, 2));
        b   = 32'($urandom_range(0, 15));
        res = a + b;
        ref_store(mop, msz, res, rt, wen, wd);
        issue(mk(32'h0000_0600, 4'd0, a, b, rt, mop, msz, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 3'b000));
        chk_bus("rand_mem_bus", ex_to_mem_bus,
                exp_bus(32'h600, 1'b1, wen, mop, msz, 1'b0, 1'b0, 5'd0, res));
        chk("rand_mem_wen", 32'(data_sram_wen), 32'(wen));
        chk("rand_mem_load", 32'(ex_is_load_o), 32'(mop == 2'b01));
        if (mop == 2'b10) chk("rand_mem_wdata", data_sram_wdata, wd);
      end else if (sel == 6) begin
        if ($urandom_range(0, 1) == 1) begin
          issue(i_mt(3'b001, a));
          m_hi = a;
        end else begin
          issue(i_mt(3'b010, a));
          m_lo = a;
        end
      end else if (sel == 7) begin
        issue(i_alu(4'd12, 32'h0, 32'h0));
        chk("rand_mfhi", ex_wdata_o, m_hi);
        issue(i_alu(4'd13, 32'h0, 32'h0));
        chk("rand_mflo", ex_wdata_o, m_lo);
      end else if (sel == 8) begin
        logic sgn;
        int mode;
        sgn  = 1'($urandom_range(0, 1));
        mode = int'($urandom_range(0, 7));
        if (mode == 0) b = 32'h0;
        else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        else if (mode == 2) begin a = 32'($signed(32'($urandom_range(0, 100))) - 50); b = 32'($urandom_range(1, 9)); end
        else b = b >> $urandom_range(0, 31);
        ref_div(sgn, a, b, q, r);
        run_div(i_div(sgn ? 2'b01 : 2'b10, a, b), cyc);
        chk("rand_div_cycles", 32'(cyc), (b == 32'h0) ? 32'd1 : 32'd33);
        m_hi = r;
        m_lo = q;
      end else begin
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        issue(i_div(2'b11, a, b));
        chk("rand_mult_nostall", 32'(stallreq_ex), 32'd0);
`ifdef EX_MUL_EN
        m_hi = 32'(p >>> 32);
        m_lo = 32'(p);
`endif
      end
    end
    issue(i_alu(4'd12, 32'h0, 32'h0));
    chk("final_hi", ex_wdata_o, m_hi);
    issue(i_alu(4'd13, 32'h0, 32'h0));
    chk("final_lo", ex_wdata_o, m_lo);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
